// File: rtl/tape_encoder.sv
// rtl/tape_encoder.sv - cassette tape encoder with a 4-byte input FIFO and pulse-width bit cells.
// Optional leader tone is built only when TAPE_PILOT_EN is defined.
module tape_encoder #(
    parameter int          UNIT         = 3600,
    parameter int          PILOT_CYCLES = 256,
    parameter logic [7:0]  AMP          = 8'h40
) (
    input  logic        clk18,
    input  logic        reset_n,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        busy,
    output logic        tapeout,
    output logic [15:0] pcm_out
);

    localparam int CW = $clog2(2 * UNIT);
    localparam logic [CW-1:0] UNIT_M1  = CW'(UNIT - 1);
    localparam logic [CW-1:0] UNIT2_M1 = CW'(2 * UNIT - 1);

    generate
        if (UNIT < 2 || UNIT > 65535 || PILOT_CYCLES < 1) begin : g_bad_params
            $error("tape_encoder: UNIT must be 2..65535 and PILOT_CYCLES at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, PILOT, SYNC_HI, SYNC_LO, DATA_HI, DATA_LO} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tapeout_q, tapeout_d;
    logic [15:0]     pcm_q, pcm_d;
    logic            running_q, running_d;

`ifdef TAPE_PILOT_EN
    localparam int HW = $clog2(2 * PILOT_CYCLES);
    localparam logic [HW-1:0] HALF_LAST = HW'(2 * PILOT_CYCLES - 1);
    logic [HW-1:0]   half_q, half_d;
`endif

    logic [7:0]      mem_q [4];
    logic [7:0]      mem_d [4];
    logic [1:0]      wr_ptr_q, wr_ptr_d;
    logic [1:0]      rd_ptr_q, rd_ptr_d;
    logic [2:0]      count_q, count_d;
    logic            push, pop, fifo_empty, start_byte;

    assign fifo_empty = (count_q == 3'd0);
    assign data_ready = running_q && (count_q != 3'd4);
    assign push       = data_valid && data_ready;
    assign pop        = start_byte;
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign tapeout    = tapeout_q;
    assign pcm_out    = pcm_q;
    assign running_d  = 1'b1;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        start_byte = 1'b0;
`ifdef TAPE_PILOT_EN
        half_d     = half_q;
`endif
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
`ifdef TAPE_PILOT_EN
                    state_d = PILOT;
                    half_d  = '0;
                    cnt_d   = UNIT_M1;
`else
                    start_byte = 1'b1;
`endif
                end
            end
`ifdef TAPE_PILOT_EN
            PILOT: begin
                // Even halves are high, odd halves low; the last low half hands over to the first byte.
                if (cnt_q == '0) begin
                    if (half_q == HALF_LAST) begin
                        start_byte = 1'b1;
                    end else begin
                        half_d = half_q + 1'b1;
                        cnt_d  = UNIT_M1;
                    end
                end
            end
`endif
            SYNC_HI: begin
                if (cnt_q == '0) begin
                    state_d = SYNC_LO;
                    cnt_d   = UNIT_M1;
                end
            end
            SYNC_LO: begin
                if (cnt_q == '0) begin
                    state_d = DATA_HI;
                    cnt_d   = shift_q[0] ? UNIT2_M1 : UNIT_M1;
                end
            end
            DATA_HI: begin
                if (cnt_q == '0) begin
                    state_d = DATA_LO;
                    cnt_d   = shift_q[0] ? UNIT2_M1 : UNIT_M1;
                end
            end
            DATA_LO: begin
                if (cnt_q == '0) begin
                    if (bit_idx_q == 3'd7) begin
                        if (!fifo_empty) begin
                            start_byte = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d   = SYNC_HI;
                        cnt_d     = UNIT_M1;
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // The FIFO head is captured on the same edge that enters the first sync pulse of a byte.
        if (start_byte) begin
            state_d   = SYNC_HI;
            cnt_d     = UNIT_M1;
            bit_idx_d = 3'd0;
            shift_d   = mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        tapeout_d = 1'b0;
        case (state_d)
`ifdef TAPE_PILOT_EN
            PILOT:            tapeout_d = ~half_d[0];
`endif
            SYNC_HI, DATA_HI: tapeout_d = 1'b1;
            default:          tapeout_d = 1'b0;
        endcase
        pcm_d = tapeout_d ? {AMP, 8'h00} : 16'h0000;
    end

    always_ff @(posedge clk18) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tapeout_q <= 1'b0;
            pcm_q     <= 16'h0000;
            running_q <= 1'b0;
            wr_ptr_q  <= 2'd0;
            rd_ptr_q  <= 2'd0;
            count_q   <= 3'd0;
`ifdef TAPE_PILOT_EN
            half_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tapeout_q <= tapeout_d;
            pcm_q     <= pcm_d;
            running_q <= running_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
`ifdef TAPE_PILOT_EN
            half_q    <= half_d;
`endif
        end
    end

    always_ff @(posedge clk18) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_tape_encoder.sv
// tb/tb_tape_encoder.sv - scoreboard bench for tape_encoder: expected waveform run lengths vs observed.
module tb_tape_encoder;

    localparam int UNIT = 4;
    localparam int PC   = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic        busy;
    logic        tapeout;
    logic [15:0] pcm_out;

    always #5 clk = ~clk;

    tape_encoder #(.UNIT(UNIT), .PILOT_CYCLES(PC), .AMP(8'h40)) dut (
        .clk18      (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .tapeout    (tapeout),
        .pcm_out    (pcm_out)
    );

`ifdef TAPE_PILOT_EN
    localparam bit PILOT_ON = 1'b1;
`else
    localparam bit PILOT_ON = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    bit mon_en = 1'b0;

    // Positive entries are high runs, negative entries low runs, in clk18 cycles.
    int   cur_len = 0;
    logic cur_lvl;
    bit   pcm_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name,
                     $signed(act), act, $signed(exp), exp);
        end
    endtask

    task automatic close_run();
        int act;
        int e;
        act = (cur_lvl === 1'b1) ? cur_len : -cur_len;
        if (exp_q.size() == 0) begin
            check("segment_unexpected", act, 0);
        end else begin
            e = exp_q.pop_front();
            check("segment", act, e);
        end
        check("pcm_tracks_tapeout", {31'd0, pcm_bad}, 32'd0);
        cur_len = 0;
    endtask

    always @(negedge clk) begin
        if (!mon_en) begin
            cur_len = 0;
        end else if (busy === 1'b1) begin
            if (cur_len > 0 && tapeout !== cur_lvl) close_run();
            if (cur_len == 0) begin
                cur_lvl = tapeout;
                pcm_bad = 1'b0;
            end
            cur_len++;
            if (pcm_out !== (tapeout === 1'b1 ? 16'h4000 : 16'h0000)) pcm_bad = 1'b1;
        end else if (cur_len > 0) begin
            close_run();
        end
    end

    task automatic exp_start();
        exp_q.push_back(-1);
        if (PILOT_ON) begin
            for (int i = 0; i < PC; i++) begin
                exp_q.push_back(UNIT);
                exp_q.push_back(-UNIT);
            end
        end
    endtask

    task automatic exp_byte(input logic [7:0] b);
        int k;
        for (int i = 0; i < 8; i++) begin
            k = b[i] ? 2 : 1;
            exp_q.push_back(UNIT);
            exp_q.push_back(-UNIT);
            exp_q.push_back(k * UNIT);
            exp_q.push_back(-k * UNIT);
        end
    endtask

    task automatic send(input logic [7:0] b, output int waits);
        @(negedge clk);
        data_in    = b;
        data_valid = 1'b1;
        waits      = 0;
        while (data_ready !== 1'b1 && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_tape_low"}, {31'd0, tapeout}, 32'd0);
    endtask

    initial begin
        int w;
        logic [7:0] five [5];
        five[0] = 8'h3C; five[1] = 8'h81; five[2] = 8'h00; five[3] = 8'hFF; five[4] = 8'h5A;

        reset_n    = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tapeout", {31'd0, tapeout}, 32'd0);
        check("rst_pcm", {16'd0, pcm_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, data_ready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", {31'd0, data_ready}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("idle_tapeout", {31'd0, tapeout}, 32'd0);
        check("idle_pcm", {16'd0, pcm_out}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_ready", {31'd0, data_ready}, 32'd1);

        mon_en = 1'b1;

        exp_start();
        exp_byte(8'h00);
        send(8'h00, w);
        data_valid = 1'b0;
        check("b00_wait", w, 0);
        wait_idle("b00");

        exp_start();
        exp_byte(8'hFF);
        send(8'hFF, w);
        data_valid = 1'b0;
        check("bff_wait", w, 0);
        wait_idle("bff");

        // Five bytes with data_valid held: the fifth waits for the first pop when a pilot is built.
        exp_start();
        for (int i = 0; i < 5; i++) exp_byte(five[i]);
        for (int i = 0; i < 4; i++) begin
            send(five[i], w);
            check("burst_wait", w, 0);
        end
        check("burst_ready_after_4", {31'd0, data_ready}, PILOT_ON ? 32'd0 : 32'd1);
        send(five[4], w);
        data_valid = 1'b0;
        check("burst_wait_5th", w, PILOT_ON ? 14 : 0);
        wait_idle("burst");

        // Reset during DATA_HI of bit 3 of 8'hA5, with two more bytes queued behind it.
        mon_en = 1'b0;
        exp_q.delete();
        send(8'hA5, w);
        send(8'h33, w);
        send(8'h44, w);
        data_valid = 1'b0;
        repeat (PILOT_ON ? 88 : 72) @(posedge clk);
        #1;
        check("abort_in_data_hi", {31'd0, tapeout}, 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_tapeout", {31'd0, tapeout}, 32'd0);
        check("abort_pcm", {16'd0, pcm_out}, 32'd0);
        check("abort_fifo_empty", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, data_ready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready_release", {31'd0, data_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("abort_stays_idle", {31'd0, busy}, 32'd0);

        mon_en = 1'b1;
        exp_start();
        exp_byte(8'h01);
        send(8'h01, w);
        data_valid = 1'b0;
        wait_idle("after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
